// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT    = 2'b01,
    ST_CAPTURE = 2'b10
  } fetch_state_t;

  localparam int          PC_INC           = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          WAIT_MIN         = 1;
  localparam int          WAIT_MAX         = 15;

  // Out-of-range wait counts are pulled back into the range the 4-bit counter can hold.
  function automatic int clamp_wait(input int cycles);
    if (cycles < WAIT_MIN) return WAIT_MIN;
    if (cycles > WAIT_MAX) return WAIT_MAX;
    return cycles;
  endfunction

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter with aligned load, increment and sticky misalign flag
module pc_register
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              increment,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              misalign
);

  logic [ADDR_W-1:0] pc_aligned;
  logic              target_misaligned;

  assign pc_plus4          = pc + ADDR_W'(PC_INC);
  assign pc_aligned        = {pc_next[ADDR_W-1:2], 2'b00};
  assign target_misaligned = |pc_next[1:0];

  // A redirect wins if both are ever raised together; the fetch FSM never does so.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else if (load) begin
      pc       <= pc_aligned;
      misalign <= misalign | target_misaligned;
    end else if (increment) begin
      pc       <= pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multicycle fetch stage: PC, memory wait counter and instruction register
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  output logic              fetch_ready,
  input  logic              pc_write,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ADDR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              misalign
);

  localparam int         WAIT_EFF  = clamp_wait(WAIT_CYCLES);
  localparam logic [3:0] CNT_START = 4'(WAIT_EFF - 1);

  fetch_state_t state;
  logic [3:0]   cnt;
  logic         pc_load;
  logic         pc_inc;

  assign pc_load   = (state == ST_IDLE) && pc_write;
  assign pc_inc    = (state == ST_CAPTURE);
  assign imem_addr = pc;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk       (clk),
    .reset     (reset),
    .load      (pc_load),
    .increment (pc_inc),
    .pc_next   (pc_next),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .misalign  (misalign)
  );

  // The PC only moves in IDLE (redirect) or CAPTURE (increment), so the address
  // presented to memory is stable for the whole wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      ir          <= '0;
      ir_valid    <= 1'b0;
      fetch_ready <= 1'b1;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fetch_req && !pc_write) begin
            cnt         <= CNT_START;
            state       <= ST_WAIT;
            fetch_ready <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_CAPTURE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          ir          <= imem_instr;
          ir_valid    <= 1'b1;
          state       <= ST_IDLE;
          fetch_ready <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          fetch_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit against a cycle model
module tb_instr_fetch_unit;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        fetch_ready;
  logic        pc_write = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_fetch_unit #(
    .ADDR_W      (32),
    .WAIT_CYCLES (WC),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_ready (fetch_ready),
    .pc_write    (pc_write),
    .pc_next     (pc_next),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0)  return 32'h8C01_0004;
    if (addr < 32'h80)  return 32'h1000_0000 + {2'b00, addr[31:2]};
    return addr ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a fetch is just "edges remaining until capture"; zero means idle.
  int          m_left;
  logic [31:0] m_pc, m_ir;
  logic        m_valid, m_mis;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_pc = 32'h0; m_ir = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_left == 0) begin
        if (pc_write) begin
          m_pc  = pc_next & 32'hFFFF_FFFC;
          m_mis = m_mis | (pc_next[1:0] != 2'b00);
        end else if (fetch_req) begin
          m_left = WC + 1;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_ir    = mem_word(m_pc);
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model.fetch_ready", {31'b0, fetch_ready}, {31'b0, m_left == 0});
      chk("model.ir_valid",    {31'b0, ir_valid},    {31'b0, m_valid});
      chk("model.ir",          ir,                   m_ir);
      chk("model.pc",          pc,                   m_pc);
      chk("model.imem_addr",   imem_addr,            m_pc);
      chk("model.pc_plus4",    pc_plus4,             m_pc + 32'd4);
      chk("model.misalign",    {31'b0, misalign},    {31'b0, m_mis});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    pc_write = 1'b1; pc_next = target;
    tick();
    pc_write = 1'b0;
  endtask

  task automatic one_fetch();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    repeat (WC + 1) tick();
  endtask

  int pulses;

  initial begin
    // Reset state
    #2;
    chk("reset.pc", pc, 32'h0);
    chk("reset.ir", ir, 32'h0);
    chk("reset.ir_valid", {31'b0, ir_valid}, 32'h0);
    chk("reset.misalign", {31'b0, misalign}, 32'h0);
    tick(); tick();
    reset = 1'b0;
    chk("reset.fetch_ready", {31'b0, fetch_ready}, 32'h1);

    // First fetch: latency WC+1 edges, address held through the wait
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("first.busy", {31'b0, fetch_ready}, 32'h0);
    chk("first.addr0", imem_addr, 32'h0);
    tick();
    chk("first.addr1", imem_addr, 32'h0);
    tick();
    chk("first.no_early_valid", {31'b0, ir_valid}, 32'h0);
    tick();
    chk("first.ir", ir, 32'h8C01_0004);
    chk("first.ir_valid", {31'b0, ir_valid}, 32'h1);
    chk("first.pc", pc, 32'h4);
    tick();
    chk("first.pulse_end", {31'b0, ir_valid}, 32'h0);

    // Sequential stream: 4 fetches, one every WC+2 cycles
    redirect(32'h0);
    fetch_req = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4 * (WC + 2); i++) begin
      tick();
      if (ir_valid) begin
        pulses++;
        chk("stream.pc_step", pc, 32'(4 * pulses));
      end
    end
    fetch_req = 1'b0;
    chk("stream.pulses", 32'(pulses), 32'd4);
    chk("stream.final_pc", pc, 32'h10);
    chk("stream.last_ir", ir, 32'h1000_0003);
    tick();

    // Redirect has priority over a simultaneous request
    pc_write = 1'b1; pc_next = 32'h40; fetch_req = 1'b1;
    tick();
    pc_write = 1'b0;
    chk("redir.pc", pc, 32'h40);
    chk("redir.not_accepted", {31'b0, fetch_ready}, 32'h1);
    tick();
    fetch_req = 1'b0;
    repeat (WC + 1) tick();
    chk("redir.ir", ir, 32'h1000_0010);
    chk("redir.valid", {31'b0, ir_valid}, 32'h1);

    // Misaligned target is forced aligned and the flag sticks
    redirect(32'h23);
    chk("mis.pc", pc, 32'h20);
    chk("mis.flag", {31'b0, misalign}, 32'h1);
    one_fetch();
    chk("mis.ir", ir, 32'h1000_0008);
    redirect(32'h30);
    chk("mis.sticky", {31'b0, misalign}, 32'h1);

    // Reset during WAIT abandons the fetch
    redirect(32'h8);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst.pc", pc, 32'h0);
    chk("midrst.ir", ir, 32'h0);
    chk("midrst.misalign", {31'b0, misalign}, 32'h0);
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ir_valid) pulses++;
    end
    chk("midrst.no_pulse", 32'(pulses), 32'd0);
    chk("midrst.ready", {31'b0, fetch_ready}, 32'h1);

    // Wrap at the top of memory; redirect during WAIT is ignored
    redirect(32'hFFFF_FFFC);
    chk("wrap.pc_plus4", pc_plus4, 32'h0);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    pc_write = 1'b1; pc_next = 32'h100;
    tick();
    pc_write = 1'b0;
    chk("wrap.ignored_write", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap.pc", pc, 32'h0);
    chk("wrap.ir", ir, 32'hFFFF_FFFC ^ 32'hDEAD_BEEF);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
